// File: rtl/dmem_pkg.sv
// dmem_pkg: shared types and default sizes for the data-memory responder.
package dmem_pkg;

   localparam int DMEM_ADDR_W = 10;
   localparam int DMEM_DATA_W = 32;
   localparam int DMEM_BE_W   = DMEM_DATA_W / 8;

   localparam logic [DMEM_DATA_W-1:0] DMEM_ZERO_WORD = '0;

   typedef enum logic [1:0] {
      CLEAR,
      IDLE,
      RESP
   } dmem_state_e;

endpackage

// File: rtl/dmem_array.sv
// dmem_array: single-port synchronous RAM with byte-lane write enables and a
// registered read port. Out-of-range writes are dropped and out-of-range reads
// return zero. With DMEM_PARITY_EN defined, one even-parity bit per lane is
// stored alongside the data and checked on every read.
module dmem_array #(
   parameter int ADDR_W = 10,
   parameter int DATA_W = 32,
   parameter int DEPTH  = 1024
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                wr_en,
   input  logic                rd_en,
   input  logic [DATA_W/8-1:0] be,
   input  logic [ADDR_W-1:0]   addr,
   input  logic [DATA_W-1:0]   wdata,
`ifdef DMEM_PARITY_EN
   input  logic                par_flip,
   output logic                rd_err,
`endif
   output logic [DATA_W-1:0]   rdata
);

   localparam int BE_W  = DATA_W / 8;
   localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [ADDR_W:0] DEPTH_LIM = (ADDR_W+1)'(DEPTH);

   logic [DATA_W-1:0] mem [DEPTH];
   logic              in_range;
   logic [IDX_W-1:0]  idx;

   assign in_range = ({1'b0, addr} < DEPTH_LIM);
   assign idx      = addr[IDX_W-1:0];

   // byte-lane data write; array contents are never reset
   always_ff @(posedge clk) begin
      if (wr_en && in_range) begin
         for (int unsigned i = 0; i < BE_W; i++) begin
            if (be[i]) mem[idx][8*i +: 8] <= wdata[8*i +: 8];
         end
      end
   end

`ifdef DMEM_PARITY_EN
   logic [BE_W-1:0] par [DEPTH];
   logic [BE_W-1:0] rd_par_calc;

   // per-lane parity write; par_flip corrupts lane 0 for error injection
   always_ff @(posedge clk) begin
      if (wr_en && in_range) begin
         for (int unsigned i = 0; i < BE_W; i++) begin
            if (be[i]) par[idx][i] <= (^wdata[8*i +: 8]) ^ ((i == 0) && par_flip);
         end
      end
   end

   // recompute parity of the addressed word for comparison on read
   always_comb begin
      rd_par_calc = '0;
      for (int unsigned i = 0; i < BE_W; i++) begin
         rd_par_calc[i] = ^mem[idx][8*i +: 8];
      end
   end

   // error flag is only high in the cycle following a read accept
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         rd_err <= 1'b0;
      end else begin
         rd_err <= rd_en && in_range && (|(par[idx] ^ rd_par_calc));
      end
   end
`endif

   // registered read; holds the last read value between reads
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         rdata <= '0;
      end else if (rd_en) begin
         rdata <= in_range ? mem[idx] : '0;
      end
   end

endmodule

// File: rtl/dmem_responder.sv
// dmem_responder: REQ/ACK single-word load/store responder in front of
// dmem_array. After reset an optional sweep zero-clears the array (BUSY high).
// Optional feature macro: DMEM_PARITY_EN (per-lane parity, ERR output,
// PAR_FLIP debug input).
module dmem_responder
   import dmem_pkg::*;
#(
   parameter int ADDR_W         = DMEM_ADDR_W,
   parameter int DATA_W         = DMEM_DATA_W,
   parameter int DEPTH          = 1024,
   parameter int CLEAR_ON_RESET = 1
) (
   input  logic                CLK,
   input  logic                RESET,
   input  logic                REQ,
   input  logic                WE,
   input  logic [DATA_W/8-1:0] BE,
   input  logic [ADDR_W-1:0]   ADDRESS,
   input  logic [DATA_W-1:0]   DATA,
`ifdef DMEM_PARITY_EN
   input  logic                PAR_FLIP,
`endif
   output logic                ACK,
   output logic [DATA_W-1:0]   Q,
   output logic                BUSY,
   output logic                ERR
);

   localparam dmem_state_e      RESET_STATE = (CLEAR_ON_RESET != 0) ? CLEAR : IDLE;
   localparam logic [ADDR_W-1:0] LAST_ADDR  = ADDR_W'(DEPTH - 1);

   dmem_state_e         state_q, state_d;
   logic [ADDR_W-1:0]   clr_addr_q, clr_addr_d;
   logic                arr_wr_en, arr_rd_en;
   logic [DATA_W/8-1:0] arr_be;
   logic [ADDR_W-1:0]   arr_addr;
   logic [DATA_W-1:0]   arr_wdata;

   // state and sweep-counter registers
   always_ff @(posedge CLK) begin
      if (!RESET) begin
         state_q    <= RESET_STATE;
         clr_addr_q <= '0;
      end else begin
         state_q    <= state_d;
         clr_addr_q <= clr_addr_d;
      end
   end

   // next-state and array-port steering; array accesses are suppressed
   // on a reset edge so nothing commits while RESET is low
   always_comb begin
      state_d    = state_q;
      clr_addr_d = clr_addr_q;
      arr_wr_en  = 1'b0;
      arr_rd_en  = 1'b0;
      arr_be     = BE;
      arr_addr   = ADDRESS;
      arr_wdata  = DATA;
      case (state_q)
         CLEAR: begin
            arr_wr_en  = RESET;
            arr_be     = '1;
            arr_addr   = clr_addr_q;
            arr_wdata  = '0;
            clr_addr_d = clr_addr_q + 1'b1;
            if (clr_addr_q == LAST_ADDR) begin
               clr_addr_d = '0;
               state_d    = IDLE;
            end
         end
         IDLE: begin
            if (REQ) begin
               arr_wr_en = RESET && WE;
               arr_rd_en = RESET && !WE;
               state_d   = RESP;
            end
         end
         RESP: begin
            state_d = IDLE;
         end
         default: begin
            state_d = RESET_STATE;
         end
      endcase
   end

   // ACK is exactly the single RESP cycle; BUSY is exactly the sweep
   assign ACK  = (state_q == RESP);
   assign BUSY = (state_q == CLEAR);

`ifdef DMEM_PARITY_EN
   logic arr_par_flip;
   assign arr_par_flip = PAR_FLIP && (state_q == IDLE);
`endif

   dmem_array #(
      .ADDR_W (ADDR_W),
      .DATA_W (DATA_W),
      .DEPTH  (DEPTH)
   ) u_array (
      .clk      (CLK),
      .rst_n    (RESET),
      .wr_en    (arr_wr_en),
      .rd_en    (arr_rd_en),
      .be       (arr_be),
      .addr     (arr_addr),
      .wdata    (arr_wdata),
`ifdef DMEM_PARITY_EN
      .par_flip (arr_par_flip),
      .rd_err   (ERR),
`endif
      .rdata    (Q)
   );

`ifndef DMEM_PARITY_EN
   assign ERR = 1'b0;
`endif

endmodule

// File: doc/dmem_responder.md
Name: dmem_responder

Overview:
Data-memory responder for the processor's load/store path: it accepts single-word read/write requests over a REQ/ACK handshake and answers from an internal synchronous RAM with per-byte write enables.
- After every reset it zero-clears the whole array with a sequential sweep, so simulations and the core start from a known image.
- It sits between the core's memory stage (initiator) and the storage array.

Parameters:
- ADDR_W, 10, word-address width.
- DATA_W, 32, data word width (multiple of 8).
- DEPTH, 1024, number of words; must be <= 2^ADDR_W.
- CLEAR_ON_RESET, 1: 1 = sweep-clear array after reset; 0 = skip sweep.

Ports:
- CLK  in  1  system clock, all logic on rising edge.
- RESET  in  1  synchronous, active-low reset.
- REQ  in  1  request valid; held high until ACK seen.
- WE  in  1  1 = write, 0 = read; qualified by REQ.
- BE  in  DATA_W/8  byte-lane write enables (bit i = DATA[8i+7:8i]).
- ADDRESS  in  ADDR_W  word address.
- DATA  in  DATA_W  write data.
- ACK  out  1  one-cycle completion pulse.
- Q  out  DATA_W  read data, valid when ACK is high after a read.
- BUSY  out  1  high while the clear sweep runs; requests are not accepted.
- ERR  out  1  read parity error, valid with ACK (optional feature).

Behaviour:
- **Reset:** RESET is synchronous and active-low, sampled on the CLK rising edge. While RESET=0:
  - state<=CLEAR, or IDLE if CLEAR_ON_RESET=0;
  - clr_addr<=0, ACK<=0, Q<=0, ERR<=0;
  - BUSY<=CLEAR_ON_RESET.
- **States:** CLEAR, IDLE, RESP.
- **CLEAR:**
  - Each cycle writes 0 to mem[clr_addr] (all lanes) and increments clr_addr.
  - After writing DEPTH-1, goes to IDLE with BUSY<=0. The sweep takes exactly DEPTH cycles after reset release.
  - REQ is ignored; ACK stays 0.
- **IDLE, REQ=1 and WE=1:**
  - At this edge, lanes with BE[i]=1 are written; other lanes are unchanged.
  - Next cycle: ACK=1, state RESP. Q is unchanged.
- **IDLE, REQ=1 and WE=0:**
  - At this edge, mem[ADDRESS] is registered into Q.
  - Next cycle: ACK=1 with Q valid, state RESP.
- **RESP:**
  - ACK=1 for exactly this cycle; REQ is ignored.
  - Next state is IDLE with ACK<=0.
  - Maximum throughput is one transaction per 2 cycles.
- **Latency:** 1 cycle from the accepting edge to ACK, for reads and writes.
- **Initiator rule:** REQ/WE/ADDRESS/DATA/BE stay stable until ACK. A REQ still high in the cycle after ACK is treated as a new request.
- **Q hold:** Q holds the last read value until the next read completes. Writes and clear never alter Q.
- **BE=0 write:** no array change; still ACKed.
- **Out of range (ADDRESS >= DEPTH):** write is dropped; read returns Q=0; ACK is still given.
- **Read after write, same address:** the next read returns the new data (no bypass is needed because of the RESP gap).
- **Reset mid-operation:**
  - A pending ACK is cancelled and a half-finished sweep restarts at 0.
  - A write committed before the reset edge is then overwritten by the sweep if CLEAR_ON_RESET=1.

Optional Feature:
- **DMEM_PARITY_EN defined:**
  - One even-parity bit is stored per byte lane and written with the data; the clear sweep stores parity 0.
  - On a read, all lanes are checked; ERR=1 with ACK on any mismatch, otherwise 0.
  - ERR is 0 whenever ACK=0.
  - A debug-only input PAR_FLIP (1 bit) inverts the stored parity of lane 0 on writes, for test.
- **Not defined:** no parity storage, no PAR_FLIP port, ERR tied to 0.

Decomposition:
- **Package dmem_pkg:**
  - state enum {CLEAR, IDLE, RESP};
  - defaults DMEM_ADDR_W=10, DMEM_DATA_W=32;
  - DMEM_BE_W = DATA_W/8;
  - zero-word constant.
- **Sub-module dmem_array:** single-port synchronous RAM with byte-lane write enables and registered read (plus parity bits under DMEM_PARITY_EN). dmem_responder holds the FSM, clear counter and handshake.

Test Plan:
- Release RESET with CLEAR_ON_RESET=1 -> BUSY high exactly 1024 cycles, REQ held high meanwhile gets no ACK; then a read of addresses 0, 511, 1023 returns 0x00000000.
- Write 0x12345678 with BE=4'b1111 to address 5, then read address 5 -> ACK 1 cycle after each accept; Q=0x12345678.
- Read-modify-write loop over all 1024 addresses (read, Q+1, write back), twice -> final read of every address returns 0x00000002.
- Address 9 holds 0xAABBCCDD; write 0x11223344 with BE=4'b0101 -> read returns 0xAA22CC44; a BE=0 write is still ACKed and leaves the data unchanged.
- Assert RESET during a read's ACK cycle and mid-sweep (at clr_addr=300) -> ACK=0 and Q=0 next cycle, sweep restarts, BUSY high for a full 1024 cycles.
- DMEM_PARITY_EN: a normal write/read gives ERR=0; a write with PAR_FLIP=1 then a read of the same address gives ERR=1 with ACK; without the macro, ERR is always 0.
